// File: rtl/arb_pkg.sv
// Shared arbitration types and sizing for the requester arbiters.
package arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;

    // Arbiter ownership state
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Result of a rotating-priority search
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } arb_pick_t;

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 binary to one-hot decoder.
module decoder_2to4 (
    input  logic [1:0] sel,
    output logic [3:0] dec
);

    // Set exactly the bit addressed by sel
    always_comb begin
        dec      = '0;
        dec[sel] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered owner index.
// A grant is held while the owner keeps requesting; the rotating pointer
// provides fairness.
// Optional macro RR_ARBITER_4_TIMEOUT_EN adds a hold-time limit of MAX_HOLD
// cycles when another requester is waiting.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid
);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
        $error("rr_arbiter_4: MAX_HOLD must be in 1..15");
    end

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic [NREQ-1:0]  dec_out;
    arb_pick_t        pick_all;
    logic             new_grant;
    arb_pick_t        new_pick;

`ifdef RR_ARBITER_4_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    logic [3:0]      hold_cnt, hold_nxt;
    logic [NREQ-1:0] owner_mask;
    arb_pick_t       pick_oth;
`endif

    // First set bit of r in the order p, p+1, p+2, p+3 (mod 4)
    function automatic arb_pick_t rr_pick(input logic [NREQ-1:0] r,
                                          input logic [IDX_W-1:0] p);
        arb_pick_t        res;
        logic [IDX_W-1:0] k;
        res.found = 1'b0;
        res.idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = p + IDX_W'(i);
            if (!res.found && r[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

    // Next owner, pointer and (optionally) hold counter
    always_comb begin
        state_nxt = state;
        idx_nxt   = grant_idx;
        ptr_nxt   = ptr;
        new_grant = 1'b0;
        new_pick  = '0;
        pick_all  = rr_pick(req, ptr);
`ifdef RR_ARBITER_4_TIMEOUT_EN
        hold_nxt             = hold_cnt;
        owner_mask           = '0;
        owner_mask[grant_idx] = 1'b1;
        pick_oth             = rr_pick(req & ~owner_mask, ptr);
`endif
        unique case (state)
            ARB_IDLE: begin
                if (pick_all.found) begin
                    new_grant = 1'b1;
                    new_pick  = pick_all;
                end
            end
            ARB_BUSY: begin
                if (!req[grant_idx]) begin
                    // Owner's bit is clear, so a full search finds only others
                    if (pick_all.found) begin
                        new_grant = 1'b1;
                        new_pick  = pick_all;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
`ifdef RR_ARBITER_4_TIMEOUT_EN
                else if (hold_cnt == HOLD_LAST) begin
                    // Limit reached: pre-empt only if someone else is waiting,
                    // otherwise the counter stays saturated
                    if (pick_oth.found) begin
                        new_grant = 1'b1;
                        new_pick  = pick_oth;
                    end
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
`endif
            end
            default: state_nxt = ARB_IDLE;
        endcase

        if (new_grant) begin
            state_nxt = ARB_BUSY;
            idx_nxt   = new_pick.idx;
            ptr_nxt   = new_pick.idx + IDX_W'(1);
`ifdef RR_ARBITER_4_TIMEOUT_EN
            hold_nxt  = '0;
`endif
        end
    end

    // State, owner and pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            ptr       <= '0;
`ifdef RR_ARBITER_4_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            grant_idx <= idx_nxt;
            ptr       <= ptr_nxt;
`ifdef RR_ARBITER_4_TIMEOUT_EN
            hold_cnt  <= hold_nxt;
`endif
        end
    end

    assign grant_valid = (state == ARB_BUSY);

    decoder_2to4 u_dec (
        .sel (grant_idx),
        .dec (dec_out)
    );

    assign grant = dec_out & {NREQ{grant_valid}};

endmodule
